// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver.
// Frame format: 1 start bit (0), 8 data bits LSB first, optional even-parity
// bit, 1 stop bit (1). Received bytes are held in UART_RxREG with a
// data-valid flag that the management area clears with UART_RX_ACK.
module uart_rx #(
   parameter int OVERSAMPLE = 16,    // baud_tick strobes per bit, power of 2 (8..16)
   parameter bit PARITY_EN  = 1'b1   // 1: even-parity bit follows the data bits
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       baud_tick,
   input  logic       UART_RXD,
   input  logic       UART_RX_ACK,
   output logic [7:0] UART_RxREG,
   output logic       UART_STA_RX,
   output logic       UART_PERR,
   output logic       UART_FERR,
   output logic       UART_OVR
);

   localparam int CW = $clog2(OVERSAMPLE);
   // Tick count at which the start bit is re-checked (its mid-point).
   localparam logic [CW-1:0] MID = CW'(OVERSAMPLE / 2 - 1);
   // Tick count one full bit after the previous sample; because the count
   // restarts at mid-start, this lands on the middle of every later bit.
   localparam logic [CW-1:0] BIT_END = CW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_e;

   logic          rx_meta_q;
   logic          rxs_q;
   state_e        state_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic [2:0]    bit_idx_q;
   logic [7:0]    shift_q;
   logic [7:0]    shift_d;
   logic          perr_n_q;
   logic          at_mid;
   logic          at_end;
   logic [7:0]    rx_reg_q;
   logic          sta_q;
   logic          perr_q;
   logic          ferr_q;
   logic          ovr_q;

   // Two-flop synchronizer for the asynchronous pin; idles at the line's idle level.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values, independent of statement order between blocks.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rxs_q     <= 1'b1;
      end else begin
         rx_meta_q <= UART_RXD;
         rxs_q     <= rx_meta_q;
      end
   end

   // Next-count, next-shift and sample-point decodes shared by all states.
   always_comb begin
      cnt_d   = cnt_q + CW'(1);
      shift_d = {rxs_q, shift_q[7:1]};
      at_mid  = (cnt_q == MID);
      at_end  = (cnt_q == BIT_END);
   end

   // Receive FSM plus the registered status/data outputs; advances only on baud_tick.
   // NOTE: every register here, including the data-path ones, is given a reset
   // value so a reset mid-frame leaves no stale shift or parity state behind.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         perr_n_q  <= 1'b0;
         rx_reg_q  <= '0;
         sta_q     <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         // An acknowledge consumes the held byte; a commit later in this
         // block overrides these assignments, so a same-cycle commit wins.
         if (UART_RX_ACK) begin
            sta_q <= 1'b0;
            ovr_q <= 1'b0;
         end

         if (baud_tick) begin
            unique case (state_q)
               IDLE: begin
                  if (!rxs_q) begin
                     state_q <= START;
                     cnt_q   <= '0;
                  end
               end

               START: begin
                  if (at_mid) begin
                     if (rxs_q) begin
                        // Line went back high before mid-start: glitch.
                        state_q <= IDLE;
                     end else begin
                        state_q   <= DATA;
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                     end
                  end else begin
                     cnt_q <= cnt_d;
                  end
               end

               DATA: begin
                  if (at_end) begin
                     shift_q   <= shift_d;
                     cnt_q     <= '0;
                     bit_idx_q <= bit_idx_q + 3'd1;
                     if (bit_idx_q == 3'd7) begin
                        state_q <= PARITY_EN ? PARITY : STOP;
                     end
                  end else begin
                     cnt_q <= cnt_d;
                  end
               end

               PARITY: begin
                  if (at_end) begin
                     perr_n_q <= rxs_q ^ (^shift_q);
                     cnt_q    <= '0;
                     state_q  <= STOP;
                  end else begin
                     cnt_q <= cnt_d;
                  end
               end

               STOP: begin
                  if (at_end) begin
                     // Commit at mid-stop; returning to IDLE here lets a
                     // back-to-back start bit be seen without an idle gap.
                     rx_reg_q <= shift_q;
                     perr_q   <= PARITY_EN ? perr_n_q : 1'b0;
                     ferr_q   <= ~rxs_q;
                     sta_q    <= 1'b1;
                     ovr_q    <= UART_RX_ACK ? 1'b0 : (sta_q | ovr_q);
                     cnt_q    <= '0;
                     state_q  <= IDLE;
                  end else begin
                     cnt_q <= cnt_d;
                  end
               end

               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign UART_RxREG  = rx_reg_q;
   assign UART_STA_RX = sta_q;
   assign UART_PERR   = perr_q;
   assign UART_FERR   = ferr_q;
   assign UART_OVR    = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed plus randomized frames for uart_rx, checked against a
// frame-level model of the receiver's visible status.
module tb_uart_rx;

   localparam int OVERSAMPLE = 16;
   localparam bit PARITY_EN  = 1'b1;
   localparam int TICK_CLKS  = 4;
   localparam int BIT_CLKS   = OVERSAMPLE * TICK_CLKS;
   localparam int NBITS      = 10 + int'(PARITY_EN);
   // Frames start on the negedge just after a tick; the synchronized low is
   // first seen by the tick TICK_CLKS clocks later, and the commit follows
   // (1 + 8 + PARITY_EN) * OVERSAMPLE + OVERSAMPLE/2 ticks after that.
   localparam int COMMIT_K   = TICK_CLKS + TICK_CLKS * ((9 + int'(PARITY_EN)) * OVERSAMPLE + OVERSAMPLE / 2);
   // A point inside data bit 4 (bit slot 5 of the frame).
   localparam int ABORT_K    = 5 * BIT_CLKS + 20;

   logic       clk;
   logic       rst;
   logic       baud_tick;
   logic       UART_RXD;
   logic       UART_RX_ACK;
   logic [7:0] UART_RxREG;
   logic       UART_STA_RX;
   logic       UART_PERR;
   logic       UART_FERR;
   logic       UART_OVR;

   int n_checks = 0;
   int n_fails  = 0;

   // Expected visible state of the receiver.
   logic [7:0] m_reg;
   logic       m_sta;
   logic       m_perr;
   logic       m_ferr;
   logic       m_ovr;

   logic [7:0] r_data;
   logic       r_par;
   logic       r_stop;
   int         r_mode;

   uart_rx #(
      .OVERSAMPLE(OVERSAMPLE),
      .PARITY_EN (PARITY_EN)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .baud_tick  (baud_tick),
      .UART_RXD   (UART_RXD),
      .UART_RX_ACK(UART_RX_ACK),
      .UART_RxREG (UART_RxREG),
      .UART_STA_RX(UART_STA_RX),
      .UART_PERR  (UART_PERR),
      .UART_FERR  (UART_FERR),
      .UART_OVR   (UART_OVR)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // baud_tick: one clk high every TICK_CLKS clocks, driven on negedges.
   initial begin
      baud_tick = 1'b0;
      forever begin
         repeat (TICK_CLKS - 1) @(negedge clk);
         baud_tick = 1'b1;
         @(negedge clk);
         baud_tick = 1'b0;
      end
   end

   // Hard time limit so the run always ends.
   initial begin
      #5ms;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "time limit reached");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".rxreg"}, {24'd0, UART_RxREG}, {24'd0, m_reg});
      check({tag, ".sta"},   {31'd0, UART_STA_RX}, {31'd0, m_sta});
      check({tag, ".perr"},  {31'd0, UART_PERR},   {31'd0, m_perr});
      check({tag, ".ferr"},  {31'd0, UART_FERR},   {31'd0, m_ferr});
      check({tag, ".ovr"},   {31'd0, UART_OVR},    {31'd0, m_ovr});
   endtask

   task automatic model_reset();
      m_reg  = 8'h00;
      m_sta  = 1'b0;
      m_perr = 1'b0;
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
   endtask

   task automatic idle(input int n);
      UART_RXD = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // One-clock acknowledge pulse, then check the result.
   task automatic ack_pulse(input string tag);
      @(negedge clk);
      UART_RX_ACK = 1'b1;
      @(negedge clk);
      UART_RX_ACK = 1'b0;
      if (m_sta) begin
         m_sta = 1'b0;
         m_ovr = 1'b0;
      end
      check_all(tag);
   endtask

   // Drive one whole frame; checks the status just before and at the commit
   // clock, optionally acks in the commit cycle or aborts with a reset.
   task automatic send_frame(input string tag, input logic [7:0] data, input logic par,
                             input logic stop, input bit ack_at_commit, input bit abort);
      logic [NBITS-1:0] bits;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[1 + i] = data[i];
      if (PARITY_EN) bits[9] = par;
      bits[NBITS-1] = stop;

      @(posedge clk iff baud_tick);
      @(negedge clk);
      UART_RXD = bits[0];
      for (int k = 1; k < NBITS * BIT_CLKS; k++) begin
         @(negedge clk);
         if (k % BIT_CLKS == 0) UART_RXD = bits[k / BIT_CLKS];
         if (abort && k == ABORT_K) begin
            rst = 1'b1;
            @(negedge clk);
            rst      = 1'b0;
            UART_RXD = 1'b1;
            model_reset();
            return;
         end
         if (!abort && k == COMMIT_K - 1) begin
            check({tag, ".sta_before"}, {31'd0, UART_STA_RX}, {31'd0, m_sta});
            if (ack_at_commit) UART_RX_ACK = 1'b1;
         end
         if (!abort && k == COMMIT_K) begin
            UART_RX_ACK = 1'b0;
            m_ovr  = ack_at_commit ? 1'b0 : (m_sta | m_ovr);
            m_sta  = 1'b1;
            m_reg  = data;
            m_perr = PARITY_EN ? (par ^ (^data)) : 1'b0;
            m_ferr = ~stop;
            check_all(tag);
         end
      end
   endtask

   initial begin
      rst         = 1'b1;
      UART_RXD    = 1'b1;
      UART_RX_ACK = 1'b0;
      model_reset();
      repeat (5) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_all("reset");

      // Clean 0x55 frame with the exact commit latency, then ack.
      send_frame("f55", 8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(BIT_CLKS);
      ack_pulse("f55.ack");

      // Ack while nothing is pending changes nothing.
      ack_pulse("idle_ack");

      // 0xA7 has odd weight, so a parity bit of 0 is an error.
      send_frame("fA7", 8'hA7, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(BIT_CLKS);
      ack_pulse("fA7.ack");

      // 0x3C with the stop bit low: framing error, byte still delivered.
      send_frame("f3C", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(2 * BIT_CLKS);
      check_all("f3C.after");
      ack_pulse("f3C.ack");

      // Five-tick glitch: no commit.
      @(negedge clk);
      UART_RXD = 1'b0;
      repeat (5 * TICK_CLKS) @(negedge clk);
      idle(3 * BIT_CLKS);
      check_all("glitch");
      send_frame("f81", 8'h81, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(BIT_CLKS);
      ack_pulse("f81.ack");

      // Back-to-back frames without ack: overrun.
      send_frame("f12", 8'h12, 1'b0, 1'b1, 1'b0, 1'b0);
      send_frame("f34", 8'h34, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(BIT_CLKS);
      ack_pulse("f34.ack");

      // Ack in the commit cycle: new byte loads, overrun suppressed.
      send_frame("f5A", 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(BIT_CLKS);
      send_frame("fC3", 8'hC3, 1'b0, 1'b1, 1'b1, 1'b0);
      idle(BIT_CLKS);

      // Reset during data bit 4 with a byte pending: everything clears.
      send_frame("abort", 8'h6B, 1'b1, 1'b1, 1'b0, 1'b1);
      idle(2 * BIT_CLKS);
      check_all("abort");
      send_frame("fF0", 8'hF0, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(BIT_CLKS);

      // Random frames with random parity/stop errors and ack timing.
      for (int f = 0; f < 20; f++) begin
         r_data = 8'($urandom);
         r_par  = (^r_data) ^ ($urandom_range(3) == 0);
         r_stop = ($urandom_range(4) != 0);
         r_mode = $urandom_range(2);
         send_frame("rand", r_data, r_par, r_stop, r_mode == 2, 1'b0);
         if (r_mode == 1) ack_pulse("rand.ack");
         if (!r_stop) idle(2 * BIT_CLKS);
         else idle($urandom_range(1) * BIT_CLKS);
      end
      idle(BIT_CLKS);
      check_all("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
